load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_access_check.sv | 39 +++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access size codes,
// RISC-V load/store funct3 encodings and the control FSM state encoding.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // The unused size code 11 is treated as a word so range checks stay conservative.
  function automatic logic [2:0] size_bytes(input logic [1:0] code);
    case (code)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_access_check.sv
// Combinational decode of a load/store request: access size plus a single
// fault flag covering illegal funct3, misalignment and out-of-range addresses.
module lsu_access_check
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 512
) (
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] addr,
  output size_e       size,
  output logic        fault
);

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [32:0] last_byte;

  always_comb begin
    size = size_e'(funct3[1:0]);

    case (funct3)
      F3_LB, F3_LH, F3_LW: illegal = 1'b0;
      F3_LBU, F3_LHU:      illegal = is_store;
      default:             illegal = 1'b1;
    endcase

    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    // Widened by one bit so an access straddling 2^32 cannot wrap back into range.
    last_byte    = {1'b0, addr} + {30'b0, size_bytes(funct3[1:0]) - 3'd1};
    out_of_range = (last_byte >= 33'(MEM_BYTES));

    fault = illegal | misaligned | out_of_range;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, performs a single-cycle
// access to a big-endian data memory and returns a one-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 512
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqIsStore,
  input  logic [2:0]  ReqFunct3,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespFault,
  output logic        MemEnable,
  output logic        MemReadWrite,
  output logic        MemSignExt,
  output logic [8:0]  MemAddress,
  output logic [31:0] MemDataIn,
  output logic [1:0]  MemSize,
  input  logic [31:0] MemDataOut
);

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_fault_q, resp_fault_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_rw_q, mem_rw_d;
  logic        mem_sext_q, mem_sext_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [8:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;

  size_e       access_size;
  logic        access_fault;

  lsu_access_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_access_check (
    .funct3  (ReqFunct3),
    .is_store(ReqIsStore),
    .addr    (ReqAddr),
    .size    (access_size),
    .fault   (access_fault)
  );

  assign ReqReady = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    mem_en_d     = 1'b0;
    mem_rw_d     = 1'b0;
    mem_sext_d   = 1'b0;
    mem_size_d   = 2'b00;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;

    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          is_store_d = ReqIsStore;
          // Faulting requests skip the memory entirely and respond next cycle.
          if (access_fault) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_data_d  = 32'h0;
          end else begin
            state_d    = ACCESS;
            mem_en_d   = 1'b1;
            mem_rw_d   = ReqIsStore;
            mem_size_d = access_size;
            mem_sext_d = ~ReqIsStore & ~ReqFunct3[2];
            mem_addr_d = ReqAddr[8:0];
            mem_din_d  = ReqData;
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b0;
        resp_data_d  = is_store_q ? 32'h0 : MemDataOut;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_fault_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_sext_q   <= 1'b0;
      mem_size_q   <= 2'b00;
      mem_addr_q   <= 9'h0;
      mem_din_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      mem_sext_q   <= mem_sext_d;
      mem_size_q   <= mem_size_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
    end
  end

  assign RespValid    = resp_valid_q;
  assign RespData     = resp_data_q;
  assign RespFault    = resp_fault_q;
  assign MemEnable    = mem_en_q;
  assign MemReadWrite = mem_rw_q;
  assign MemSignExt   = mem_sext_q;
  assign MemSize      = mem_size_q;
  assign MemAddress   = mem_addr_q;
  assign MemDataIn    = mem_din_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a big-endian byte memory model that
// performs its own sign/zero extension, as the attached data memory does.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqIsStore;
  logic [2:0]  ReqFunct3;
  logic [31:0] ReqAddr;
  logic [31:0] ReqData;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespFault;
  logic        MemEnable;
  logic        MemReadWrite;
  logic        MemSignExt;
  logic [8:0]  MemAddress;
  logic [31:0] MemDataIn;
  logic [1:0]  MemSize;
  logic [31:0] MemDataOut;

  int checks = 0;
  int fails  = 0;

  logic [7:0] mem [0:511];
  int         rd_a;
  logic [15:0] rd_half;

  load_store_unit #(.MEM_BYTES(512)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqIsStore(ReqIsStore),
    .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RespValid(RespValid), .RespData(RespData), .RespFault(RespFault),
    .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemSignExt(MemSignExt),
    .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemSize(MemSize),
    .MemDataOut(MemDataOut)
  );

  always #5 Clk = ~Clk;

  // Memory read port: big-endian, returns the already-extended value.
  always_comb begin
    MemDataOut = 32'h0;
    rd_a       = 0;
    rd_half    = 16'h0;
    if (MemEnable && !MemReadWrite) begin
      rd_a    = int'(MemAddress);
      rd_half = {mem[rd_a], mem[(rd_a + 1) % 512]};
      case (MemSize)
        2'b00:   MemDataOut = MemSignExt ? {{24{mem[rd_a][7]}}, mem[rd_a]} : {24'h0, mem[rd_a]};
        2'b01:   MemDataOut = MemSignExt ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
        default: MemDataOut = {mem[rd_a], mem[(rd_a + 1) % 512], mem[(rd_a + 2) % 512], mem[(rd_a + 3) % 512]};
      endcase
    end
  end

  always @(posedge Clk) begin
    if (MemEnable && MemReadWrite) begin
      case (MemSize)
        2'b00: mem[int'(MemAddress)] <= MemDataIn[7:0];
        2'b01: begin
          mem[int'(MemAddress)]             <= MemDataIn[15:8];
          mem[(int'(MemAddress) + 1) % 512] <= MemDataIn[7:0];
        end
        default: begin
          mem[int'(MemAddress)]             <= MemDataIn[31:24];
          mem[(int'(MemAddress) + 1) % 512] <= MemDataIn[23:16];
          mem[(int'(MemAddress) + 2) % 512] <= MemDataIn[15:8];
          mem[(int'(MemAddress) + 3) % 512] <= MemDataIn[7:0];
        end
      endcase
    end
  end

  // Issues one request and observes it until the response pulse (bounded at 10 cycles).
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, output int lat, output int en_cycles,
                       output logic saw_rw, output logic [1:0] saw_size, output logic saw_sext,
                       output logic [31:0] rdata, output logic rfault);
    lat = -1; en_cycles = 0; saw_rw = 1'b0; saw_size = 2'b00; saw_sext = 1'b0;
    rdata = 32'hxxxxxxxx; rfault = 1'bx;
    @(negedge Clk);
    ReqValid = 1'b1; ReqIsStore = st; ReqFunct3 = f3; ReqAddr = addr; ReqData = data;
    @(negedge Clk);
    ReqValid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge Clk);
      if (MemEnable) begin
        en_cycles++;
        saw_rw = MemReadWrite; saw_size = MemSize; saw_sext = MemSignExt;
      end
      if (RespValid) begin
        lat = k; rdata = RespData; rfault = RespFault;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (ReqReady !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", ReqReady); end
    checks++;
    if ({RespValid, RespFault, RespData} !== 34'h0) begin
      fails++; $display("[TB] FAIL reset_resp: got v=%b f=%b d=%h expected all 0", RespValid, RespFault, RespData);
    end
    checks++;
    if ({MemEnable, MemReadWrite, MemSignExt, MemSize, MemAddress, MemDataIn} !== 46'h0) begin
      fails++; $display("[TB] FAIL reset_mem: got en=%b rw=%b sx=%b sz=%b a=%h d=%h expected all 0",
                        MemEnable, MemReadWrite, MemSignExt, MemSize, MemAddress, MemDataIn);
    end
    Reset = 1'b0;
  endtask

  task automatic test_word();
    int lat, en; logic rw, sx, f; logic [1:0] sz; logic [31:0] d;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, en, rw, sz, sx, d, f);
    checks++;
    if (lat !== 2) begin fails++; $display("[TB] FAIL sw_latency: got %0d expected 2", lat); end
    checks++;
    if ({en, rw, sz} !== {32'd1, 1'b1, 2'b10}) begin
      fails++; $display("[TB] FAIL sw_mem: got en_cycles=%0d rw=%b size=%b expected 1/1/10", en, rw, sz);
    end
    checks++;
    if ({f, d} !== 33'h0) begin fails++; $display("[TB] FAIL sw_resp: got f=%b d=%h expected 0/0", f, d); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({lat, en} !== {32'd2, 32'd1}) begin fails++; $display("[TB] FAIL lw_timing: got lat=%0d en=%0d expected 2/1", lat, en); end
    checks++;
    if ({f, d} !== {1'b0, 32'hDEADBEEF}) begin fails++; $display("[TB] FAIL lw_data: got f=%b d=%h expected 0/deadbeef", f, d); end
  endtask

  task automatic test_byte_half();
    int lat, en; logic rw, sx, f; logic [1:0] sz; logic [31:0] d;
    issue(1'b1, 3'b000, 32'h20, 32'h000000F0, lat, en, rw, sz, sx, d, f);
    issue(1'b0, 3'b000, 32'h20, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({sx, d} !== {1'b1, 32'hFFFFFFF0}) begin fails++; $display("[TB] FAIL lb_data: got sx=%b d=%h expected 1/fffffff0", sx, d); end
    issue(1'b0, 3'b100, 32'h20, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({sx, d} !== {1'b0, 32'h000000F0}) begin fails++; $display("[TB] FAIL lbu_data: got sx=%b d=%h expected 0/000000f0", sx, d); end
    issue(1'b0, 3'b001, 32'h20, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({sz, d} !== {2'b01, 32'hFFFFF000}) begin fails++; $display("[TB] FAIL lh_data: got sz=%b d=%h expected 01/fffff000", sz, d); end
    issue(1'b0, 3'b101, 32'h20, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if (d !== 32'h0000F000) begin fails++; $display("[TB] FAIL lhu_data: got %h expected 0000f000", d); end
    issue(1'b1, 3'b001, 32'h30, 32'h1234ABCD, lat, en, rw, sz, sx, d, f);
    issue(1'b0, 3'b100, 32'h31, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if (d !== 32'h000000CD) begin fails++; $display("[TB] FAIL sh_bigendian: got %h expected 000000cd", d); end
  endtask

  task automatic test_misaligned();
    int lat, en; logic rw, sx, f; logic [1:0] sz; logic [31:0] d;
    issue(1'b0, 3'b001, 32'h21, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({lat, en} !== {32'd1, 32'd0}) begin fails++; $display("[TB] FAIL lh_mis_timing: got lat=%0d en=%0d expected 1/0", lat, en); end
    checks++;
    if ({f, d} !== {1'b1, 32'h0}) begin fails++; $display("[TB] FAIL lh_mis_resp: got f=%b d=%h expected 1/0", f, d); end
    @(negedge Clk);
    checks++;
    if ({RespValid, RespFault, ReqReady} !== 3'b011) begin
      fails++; $display("[TB] FAIL resp_hold: got v=%b f=%b rdy=%b expected 0/1/1", RespValid, RespFault, ReqReady);
    end
  endtask

  task automatic test_boundaries();
    int lat, en; logic rw, sx, f; logic [1:0] sz; logic [31:0] d;
    issue(1'b1, 3'b010, 32'h1FC, 32'h12345678, lat, en, rw, sz, sx, d, f);
    issue(1'b0, 3'b010, 32'h1FC, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({lat, f, d} !== {32'd2, 1'b0, 32'h12345678}) begin fails++; $display("[TB] FAIL lw_1fc: got lat=%0d f=%b d=%h expected 2/0/12345678", lat, f, d); end
    issue(1'b0, 3'b001, 32'h1FE, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({f, d} !== {1'b0, 32'h00005678}) begin fails++; $display("[TB] FAIL lh_1fe: got f=%b d=%h expected 0/00005678", f, d); end
    issue(1'b0, 3'b010, 32'h200, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({lat, en, f} !== {32'd1, 32'd0, 1'b1}) begin fails++; $display("[TB] FAIL lw_200: got lat=%0d en=%0d f=%b expected 1/0/1", lat, en, f); end
    issue(1'b0, 3'b011, 32'h0, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({en, f} !== {32'd0, 1'b1}) begin fails++; $display("[TB] FAIL f3_011: got en=%0d f=%b expected 0/1", en, f); end
    issue(1'b1, 3'b100, 32'h20, 32'h000000AA, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({en, f} !== {32'd0, 1'b1}) begin fails++; $display("[TB] FAIL sb_f3_100: got en=%0d f=%b expected 0/1", en, f); end
    issue(1'b0, 3'b100, 32'h20, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({f, d} !== {1'b0, 32'h000000F0}) begin fails++; $display("[TB] FAIL no_write_on_fault: got f=%b d=%h expected 0/000000f0", f, d); end
    issue(1'b0, 3'b110, 32'h4, 32'h0, lat, en, rw, sz, sx, d, f);
    checks++;
    if ({lat, f} !== {32'd1, 1'b1}) begin fails++; $display("[TB] FAIL f3_110: got lat=%0d f=%b expected 1/1", lat, f); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ready_seen, resp_seen;
    int data_bad;
    ready_seen = '0; resp_seen = '0; data_bad = 0;
    @(negedge Clk);
    ReqValid = 1'b1; ReqIsStore = 1'b0; ReqFunct3 = 3'b010; ReqAddr = 32'h10; ReqData = 32'h0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge Clk);
      ready_seen[i] = ReqReady;
      resp_seen[i]  = RespValid;
      if (RespValid && (RespData !== 32'hDEADBEEF)) data_bad++;
    end
    ReqValid = 1'b0;
    checks++;
    if (ready_seen !== 12'b0010_0100_1001) begin fails++; $display("[TB] FAIL b2b_ready: got %b expected 001001001001", ready_seen); end
    checks++;
    if (resp_seen !== 12'b1001_0010_0100) begin fails++; $display("[TB] FAIL b2b_resp: got %b expected 100100100100", resp_seen); end
    checks++;
    if (data_bad !== 0) begin fails++; $display("[TB] FAIL b2b_data: got %0d bad responses expected 0", data_bad); end
  endtask

  task automatic test_reset_mid_access();
    int resp_count;
    resp_count = 0;
    @(negedge Clk);
    ReqValid = 1'b1; ReqIsStore = 1'b0; ReqFunct3 = 3'b010; ReqAddr = 32'h10; ReqData = 32'h0;
    @(negedge Clk);
    ReqValid = 1'b0;
    checks++;
    if (MemEnable !== 1'b1) begin fails++; $display("[TB] FAIL rst_pre_access: got MemEnable=%b expected 1", MemEnable); end
    #1 Reset = 1'b1;
    #1;
    checks++;
    if ({MemEnable, RespValid, ReqReady} !== 3'b001) begin
      fails++; $display("[TB] FAIL rst_mid_access: got en=%b v=%b rdy=%b expected 0/0/1", MemEnable, RespValid, ReqReady);
    end
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (RespValid) resp_count++;
    end
    checks++;
    if (resp_count !== 0) begin fails++; $display("[TB] FAIL rst_no_resp: got %0d responses expected 0", resp_count); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    Reset = 1'b1; ReqValid = 1'b0; ReqIsStore = 1'b0; ReqFunct3 = 3'b000;
    ReqAddr = 32'h0; ReqData = 32'h0;
    test_reset();
    test_word();
    test_byte_half();
    test_misaligned();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
